// File: rtl/hazard_pkg.sv
// Shared types and constants for the decode-stage hazard unit: the pipeline
// shadow-slot record and the match helper used by the per-source comparators.
package hazard_pkg;

  typedef struct packed {
    logic       valid;
    logic [4:0] rd;
    logic       reg_write;
    logic       mem_read;
  } slot_t;

  localparam logic [4:0]  REG_ZERO       = 5'd0;
  localparam logic [15:0] BUBBLE_CNT_MAX = 16'hFFFF;
  localparam slot_t       SLOT_EMPTY     = '{valid: 1'b0, rd: 5'd0, reg_write: 1'b0, mem_read: 1'b0};

  // A slot produces a value for rs when it is live, writes, and targets rs (never x0).
  function automatic logic slot_writes(input slot_t s, input logic [4:0] rs);
    return s.valid & s.reg_write & (s.rd != REG_ZERO) & (s.rd == rs);
  endfunction

endpackage

// File: rtl/hazard_match.sv
// Per-source dependency comparator: checks one decode source register against
// the EX and MEM shadow slots.
module hazard_match
  import hazard_pkg::*;
(
  input  slot_t      ex_slot,
  input  slot_t      mem_slot,
  input  logic       id_valid,
  input  logic [4:0] rs_addr,
  input  logic       use_rs,
  output logic       ex_hit,
  output logic       mem_hit,
  output logic       load_hit
);

  logic reads_s;
  logic unused_s;

  assign reads_s  = id_valid & use_rs;
  assign ex_hit   = reads_s & slot_writes(ex_slot, rs_addr);
  assign mem_hit  = reads_s & slot_writes(mem_slot, rs_addr);
  assign load_hit = ex_hit & ex_slot.mem_read;

  // The MEM load flag is carried for completeness; a load in MEM is forwardable.
  assign unused_s = mem_slot.mem_read;

endmodule

// File: rtl/hazard_unit.sv
// Decode-stage hazard unit: forwarding selects, load-use stall and bubble count.
// Define HAZARD_FWD_EN to enable forwarding; otherwise every dependency stalls.
module hazard_unit
  import hazard_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        id_valid,
  input  logic [4:0]  rs1_addr,
  input  logic [4:0]  rs2_addr,
  input  logic        use_rs1,
  input  logic        use_rs2,
  input  logic [4:0]  id_rd,
  input  logic        id_RegWrite,
  input  logic        id_MemRead,
  input  logic        flush,
  output logic        fwd_ex_1,
  output logic        fwd_mem_1,
  output logic        fwd_ex_2,
  output logic        fwd_mem_2,
  output logic        stall,
  output logic        clear,
  output logic [15:0] bubble_cnt
);

  slot_t       ex_r;
  slot_t       mem_r;
  slot_t       id_slot_s;
  logic [15:0] bubble_cnt_r;
  logic        ex_hit_1_s, mem_hit_1_s, load_hit_1_s;
  logic        ex_hit_2_s, mem_hit_2_s, load_hit_2_s;
  logic        hazard_s;
  logic        stall_s;
  logic        clear_s;

  assign id_slot_s = '{valid: 1'b1, rd: id_rd, reg_write: id_RegWrite, mem_read: id_MemRead};

  hazard_match u_match_1 (
    .ex_slot  (ex_r),
    .mem_slot (mem_r),
    .id_valid (id_valid),
    .rs_addr  (rs1_addr),
    .use_rs   (use_rs1),
    .ex_hit   (ex_hit_1_s),
    .mem_hit  (mem_hit_1_s),
    .load_hit (load_hit_1_s)
  );

  hazard_match u_match_2 (
    .ex_slot  (ex_r),
    .mem_slot (mem_r),
    .id_valid (id_valid),
    .rs_addr  (rs2_addr),
    .use_rs   (use_rs2),
    .ex_hit   (ex_hit_2_s),
    .mem_hit  (mem_hit_2_s),
    .load_hit (load_hit_2_s)
  );

`ifdef HAZARD_FWD_EN
  logic load_use_s;

  assign load_use_s = load_hit_1_s | load_hit_2_s;
  assign hazard_s   = load_use_s;
  // EX wins over MEM; EX forwarding is meaningless while the load is still in flight.
  assign fwd_ex_1   = rst & ex_hit_1_s & ~load_use_s;
  assign fwd_ex_2   = rst & ex_hit_2_s & ~load_use_s;
  assign fwd_mem_1  = rst & mem_hit_1_s & ~ex_hit_1_s;
  assign fwd_mem_2  = rst & mem_hit_2_s & ~ex_hit_2_s;
`else
  // load_hit implies ex_hit; it is folded in so both comparator outputs stay consumed.
  assign hazard_s   = ex_hit_1_s | mem_hit_1_s | load_hit_1_s |
                      ex_hit_2_s | mem_hit_2_s | load_hit_2_s;
  assign fwd_ex_1   = 1'b0;
  assign fwd_ex_2   = 1'b0;
  assign fwd_mem_1  = 1'b0;
  assign fwd_mem_2  = 1'b0;
`endif

  // A flush kills the decode instruction, so it bubbles without holding fetch.
  assign stall_s    = rst & ~flush & hazard_s;
  assign clear_s    = rst & (flush | hazard_s);
  assign stall      = stall_s;
  assign clear      = clear_s;
  assign bubble_cnt = bubble_cnt_r;

  // Shadow slots advance with the decode/execute register on the falling edge.
  always_ff @(negedge clk or negedge rst) begin
    if (!rst) begin
      ex_r  <= SLOT_EMPTY;
      mem_r <= SLOT_EMPTY;
    end else begin
      mem_r <= ex_r;
      if (id_valid && !clear_s) begin
        ex_r <= id_slot_s;
      end else begin
        ex_r <= SLOT_EMPTY;
      end
    end
  end

  // Saturating count of hazard bubbles; flush-induced bubbles are not counted.
  always_ff @(negedge clk or negedge rst) begin
    if (!rst) begin
      bubble_cnt_r <= 16'd0;
    end else if (clear_s && !flush && (bubble_cnt_r != BUBBLE_CNT_MAX)) begin
      bubble_cnt_r <= bubble_cnt_r + 16'd1;
    end else begin
      bubble_cnt_r <= bubble_cnt_r;
    end
  end

endmodule

// File: tb/tb_hazard_unit.sv
// Directed bench for hazard_unit; expectations follow HAZARD_FWD_EN when defined.
module tb_hazard_unit;

`ifdef HAZARD_FWD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  logic        clk;
  logic        rst;
  logic        id_valid;
  logic [4:0]  rs1_addr;
  logic [4:0]  rs2_addr;
  logic        use_rs1;
  logic        use_rs2;
  logic [4:0]  id_rd;
  logic        id_RegWrite;
  logic        id_MemRead;
  logic        flush;
  logic        fwd_ex_1, fwd_mem_1, fwd_ex_2, fwd_mem_2;
  logic        stall, clear;
  logic [15:0] bubble_cnt;

  int          n_cmp;
  int          n_err;
  logic [15:0] exp_cnt;

  hazard_unit dut (
    .clk         (clk),
    .rst         (rst),
    .id_valid    (id_valid),
    .rs1_addr    (rs1_addr),
    .rs2_addr    (rs2_addr),
    .use_rs1     (use_rs1),
    .use_rs2     (use_rs2),
    .id_rd       (id_rd),
    .id_RegWrite (id_RegWrite),
    .id_MemRead  (id_MemRead),
    .flush       (flush),
    .fwd_ex_1    (fwd_ex_1),
    .fwd_mem_1   (fwd_mem_1),
    .fwd_ex_2    (fwd_ex_2),
    .fwd_mem_2   (fwd_mem_2),
    .stall       (stall),
    .clear       (clear),
    .bubble_cnt  (bubble_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete within time limit");
    $fatal(1);
  end

  task automatic check_eq(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // {fwd_ex_1, fwd_mem_1, fwd_ex_2, fwd_mem_2, stall, clear}
  function automatic logic [15:0] outs();
    return {10'd0, fwd_ex_1, fwd_mem_1, fwd_ex_2, fwd_mem_2, stall, clear};
  endfunction

  // Present one decode slot just after the falling edge; return on the rising edge.
  task automatic cyc(input logic v, input logic [4:0] r1, input logic u1,
                     input logic [4:0] r2, input logic u2, input logic [4:0] rd,
                     input logic rw, input logic mr, input logic fl);
    @(negedge clk);
    #1;
    id_valid = v;  rs1_addr = r1; use_rs1 = u1; rs2_addr = r2; use_rs2 = u2;
    id_rd = rd;    id_RegWrite = rw; id_MemRead = mr; flush = fl;
    @(posedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    n_cmp = 0; n_err = 0; exp_cnt = 16'd0;
    rst = 1'b0; id_valid = 1'b1; rs1_addr = 5'd5; rs2_addr = 5'd5; use_rs1 = 1'b1;
    use_rs2 = 1'b1; id_rd = 5'd5; id_RegWrite = 1'b1; id_MemRead = 1'b1; flush = 1'b1;
    #2;
    check_eq("rst_outs", outs(), 16'd0);
    check_eq("rst_cnt", bubble_cnt, 16'd0);
    flush = 1'b0;
    #1 rst = 1'b1;

    // add x5 ; sub x6,x5,x7
    cyc(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd5, 1'b1, 1'b0, 1'b0);
    check_eq("alu_producer", outs(), 16'd0);
    cyc(1'b1, 5'd5, 1'b1, 5'd7, 1'b1, 5'd6, 1'b1, 1'b0, 1'b0);
    check_eq("alu_dep", outs(), FWD ? 16'b100000 : 16'b000011);
    if (!FWD) exp_cnt = exp_cnt + 16'd1;
    idle(1);
    check_eq("alu_idle", outs(), 16'd0);
    check_eq("alu_cnt", bubble_cnt, exp_cnt);
    idle(1);

    // add x5 ; dependent use of x5 held in decode until released
    cyc(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd5, 1'b1, 1'b0, 1'b0);
    check_eq("hold_producer", outs(), 16'd0);
    cyc(1'b1, 5'd5, 1'b1, 5'd0, 1'b0, 5'd6, 1'b1, 1'b0, 1'b0);
    check_eq("hold_ex", outs(), FWD ? 16'b100000 : 16'b000011);
    if (!FWD) exp_cnt = exp_cnt + 16'd1;
    cyc(1'b1, 5'd5, 1'b1, 5'd0, 1'b0, 5'd6, 1'b1, 1'b0, 1'b0);
    check_eq("hold_mem", outs(), FWD ? 16'b010000 : 16'b000011);
    if (!FWD) exp_cnt = exp_cnt + 16'd1;
    cyc(1'b1, 5'd5, 1'b1, 5'd0, 1'b0, 5'd6, 1'b1, 1'b0, 1'b0);
    check_eq("hold_release", outs(), 16'd0);
    check_eq("hold_cnt", bubble_cnt, exp_cnt);
    idle(2);

    // lw x5 ; add x6,x5,x5
    cyc(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd5, 1'b1, 1'b1, 1'b0);
    check_eq("lu_load", outs(), 16'd0);
    cyc(1'b1, 5'd5, 1'b1, 5'd5, 1'b1, 5'd6, 1'b1, 1'b0, 1'b0);
    check_eq("lu_stall", outs(), 16'b000011);
    exp_cnt = exp_cnt + 16'd1;
    cyc(1'b1, 5'd5, 1'b1, 5'd5, 1'b1, 5'd6, 1'b1, 1'b0, 1'b0);
    check_eq("lu_next", outs(), FWD ? 16'b010100 : 16'b000011);
    check_eq("lu_cnt", bubble_cnt, exp_cnt);
    if (!FWD) exp_cnt = exp_cnt + 16'd1;
    cyc(1'b1, 5'd5, 1'b1, 5'd5, 1'b1, 5'd6, 1'b1, 1'b0, 1'b0);
    check_eq("lu_release", outs(), 16'd0);
    check_eq("lu_cnt2", bubble_cnt, exp_cnt);
    idle(2);

    // add x0 ; use of x0
    cyc(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0);
    cyc(1'b1, 5'd0, 1'b1, 5'd0, 1'b1, 5'd6, 1'b1, 1'b0, 1'b0);
    check_eq("x0_use", outs(), 16'd0);
    idle(2);

    // producer without RegWrite
    cyc(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd5, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 5'd5, 1'b1, 5'd5, 1'b1, 5'd6, 1'b1, 1'b0, 1'b0);
    check_eq("no_regwrite", outs(), 16'd0);
    idle(2);

    // matching address but source not read
    cyc(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd5, 1'b1, 1'b0, 1'b0);
    cyc(1'b1, 5'd5, 1'b0, 5'd5, 1'b0, 5'd6, 1'b1, 1'b0, 1'b0);
    check_eq("no_use", outs(), 16'd0);
    idle(2);

    // matching address but decode empty
    cyc(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd5, 1'b1, 1'b0, 1'b0);
    cyc(1'b0, 5'd5, 1'b1, 5'd5, 1'b1, 5'd6, 1'b1, 1'b0, 1'b0);
    check_eq("no_valid", outs(), 16'd0);
    idle(2);

    // add x7 ; dependency on source 2 only, held twice
    cyc(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd7, 1'b1, 1'b0, 1'b0);
    cyc(1'b1, 5'd3, 1'b1, 5'd7, 1'b1, 5'd6, 1'b1, 1'b0, 1'b0);
    check_eq("rs2_ex", outs(), FWD ? 16'b001000 : 16'b000011);
    if (!FWD) exp_cnt = exp_cnt + 16'd1;
    cyc(1'b1, 5'd3, 1'b1, 5'd7, 1'b1, 5'd6, 1'b1, 1'b0, 1'b0);
    check_eq("rs2_mem", outs(), FWD ? 16'b000100 : 16'b000011);
    if (!FWD) exp_cnt = exp_cnt + 16'd1;
    idle(2);
    check_eq("rs2_cnt", bubble_cnt, exp_cnt);

    // flush during a load-use hazard
    cyc(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd5, 1'b1, 1'b1, 1'b0);
    cyc(1'b1, 5'd5, 1'b1, 5'd0, 1'b0, 5'd6, 1'b1, 1'b0, 1'b1);
    check_eq("flush_outs", outs(), 16'b000001);
    idle(1);
    check_eq("flush_cnt", bubble_cnt, exp_cnt);
    idle(1);

    // saturation from a preloaded count
    @(posedge clk);
    #1 force dut.bubble_cnt_r = 16'hFFFE;
    #1 release dut.bubble_cnt_r;
    exp_cnt = 16'hFFFE;
    idle(1);
    check_eq("sat_preload", bubble_cnt, exp_cnt);
    for (int k = 0; k < 3; k++) begin
      cyc(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd5, 1'b1, 1'b1, 1'b0);
      cyc(1'b1, 5'd5, 1'b1, 5'd0, 1'b0, 5'd6, 1'b1, 1'b0, 1'b0);
      check_eq("sat_lu", outs(), 16'b000011);
      idle(1);
      check_eq("sat_cnt", bubble_cnt, 16'hFFFF);
    end

    // reset asserted in mid-stall
    cyc(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd5, 1'b1, 1'b1, 1'b0);
    cyc(1'b1, 5'd5, 1'b1, 5'd0, 1'b0, 5'd6, 1'b1, 1'b0, 1'b0);
    check_eq("mid_stall", outs(), 16'b000011);
    #1 rst = 1'b0;
    #1;
    check_eq("mid_rst_outs", outs(), 16'd0);
    check_eq("mid_rst_cnt", bubble_cnt, 16'd0);
    #1 rst = 1'b1;
    cyc(1'b1, 5'd5, 1'b1, 5'd0, 1'b0, 5'd6, 1'b1, 1'b0, 1'b0);
    check_eq("post_rst_outs", outs(), 16'd0);
    check_eq("post_rst_cnt", bubble_cnt, 16'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
